// File: rtl/axi_mm2s_dma.sv
`default_nettype none
// ============================================================================
// Module   : axi_mm2s_dma
// Purpose  : Memory-mapped to stream DMA. Issues AXI INCR read bursts for a
//            transfer of xfer_len beats starting at src_addr, buffers the read
//            data in a FIFO and forwards it on an AXI-Stream master with TLAST
//            on the final beat. Bursts are only issued when the FIFO has room
//            for every outstanding beat, so RREADY can stay high while busy.
// Options  : define AXI_MM2S_4K_SPLIT_EN to keep bursts inside 4KB pages.
// Revision : 1.0 - initial release
// ============================================================================
module axi_mm2s_dma #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_BURST  = 256,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     src_addr,
    input  logic [31:0]           xfer_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    output logic [ADDR_W-1:0]     ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic [DATA_W-1:0]     RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    output logic                  TVALID,
    input  logic                  TREADY,
    output logic [DATA_W-1:0]     TDATA,
    output logic [DATA_W/8-1:0]   TKEEP,
    output logic                  TLAST
);

    localparam int                c_bytes      = DATA_W / 8;
    localparam int                c_size       = $clog2(c_bytes);
    localparam int                c_ptr_w      = $clog2(FIFO_DEPTH);
    localparam int                c_cnt_w      = c_ptr_w + 1;
    localparam logic [31:0]       c_max_burst  = 32'(MAX_BURST);
    localparam logic [31:0]       c_depth      = 32'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] c_align_mask = ~ADDR_W'(c_bytes - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_addr;      // next burst address (AR side)
    logic [ADDR_W-1:0]    r_raddr;     // address of the burst currently returning (R side)
    logic [ADDR_W-1:0]    r_araddr;
    logic [7:0]           r_arlen;
    logic                 r_arvalid;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic [31:0]          r_req_left;  // beats not yet requested
    logic [31:0]          r_rcv_left;  // beats not yet received
    logic [31:0]          r_rb_left;   // beats left in the current R burst, 0 = between bursts
    logic [31:0]          r_tx_cnt;
    logic [31:0]          r_last_idx;
    logic [c_cnt_w-1:0]   r_outst;     // requested beats not yet received
    logic [c_cnt_w-1:0]   r_fcnt;
    logic [c_ptr_w-1:0]   r_wptr;
    logic [c_ptr_w-1:0]   r_rptr;
    logic [DATA_W-1:0]    r_mem [FIFO_DEPTH];

    logic [31:0]          w_lim_ar;
    logic [31:0]          w_lim_r;
    logic [31:0]          w_blen;
    logic [31:0]          w_rblen;
    logic [31:0]          w_rcur;
    logic                 w_fit;
    logic                 w_issue;
    logic                 w_arhs;
    logic                 w_rbeat;
    logic                 w_rstray;
    logic                 w_frd;
    logic                 w_tlast_hs;
    logic [c_cnt_w-1:0]   w_out_add;

`ifdef AXI_MM2S_4K_SPLIT_EN
    // Burst cap at a given page offset: the smaller of MAX_BURST and the beats left in the 4KB page
    function automatic logic [31:0] f_cap(input logic [11:0] page_off);
        logic [31:0] to_4k;
        to_4k = (32'd4096 - {20'd0, page_off}) >> c_size;
        return (to_4k > c_max_burst) ? c_max_burst : to_4k;
    endfunction

    assign w_lim_ar = f_cap(r_addr[11:0]);
    assign w_lim_r  = f_cap(r_raddr[11:0]);
`else
    assign w_lim_ar = c_max_burst;
    assign w_lim_r  = c_max_burst;
`endif

    // The R side recomputes the same burst sequence so RLAST can be checked without a length queue
    assign w_blen     = (r_req_left > w_lim_ar) ? w_lim_ar : r_req_left;
    assign w_rblen    = (r_rcv_left > w_lim_r)  ? w_lim_r  : r_rcv_left;
    assign w_rcur     = (r_rb_left == 32'd0) ? w_rblen : r_rb_left;
    assign w_fit      = (32'(r_fcnt) + 32'(r_outst) + w_blen) <= c_depth;
    assign w_issue    = (r_state == S_REQ) && !r_arvalid && (r_req_left != 32'd0) && w_fit;
    assign w_arhs     = r_arvalid && ARREADY;
    assign w_rbeat    = RVALID && r_busy && (r_rcv_left != 32'd0);
    assign w_rstray   = RVALID && r_busy && (r_rcv_left == 32'd0);
    assign w_frd      = TVALID && TREADY;
    assign w_tlast_hs = w_frd && TLAST;
    assign w_out_add  = w_issue ? c_cnt_w'(w_blen) : '0;

    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign ARVALID = r_arvalid;
    assign ARADDR  = r_araddr;
    assign ARLEN   = r_arlen;
    assign ARSIZE  = 3'(c_size);
    assign ARBURST = 2'b01;
    assign RREADY  = r_busy;
    assign TVALID  = (r_fcnt != '0);
    assign TDATA   = r_mem[r_rptr];
    assign TKEEP   = '1;
    assign TLAST   = TVALID && (r_tx_cnt == r_last_idx);

    // FIFO storage; contents need no reset because occupancy gates TVALID
    always_ff @(posedge ACLK) begin
        if (w_rbeat) begin
            r_mem[r_wptr] <= RDATA;
        end
    end

    // Control FSM, AR issue, R-beat bookkeeping, FIFO pointers and stream beat count
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_raddr    <= '0;
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_arvalid  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_req_left <= '0;
            r_rcv_left <= '0;
            r_rb_left  <= '0;
            r_tx_cnt   <= '0;
            r_last_idx <= '0;
            r_outst    <= '0;
            r_fcnt     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_err <= 1'b0;
                        if (xfer_len == 32'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state    <= S_REQ;
                            r_busy     <= 1'b1;
                            r_addr     <= src_addr & c_align_mask;
                            r_raddr    <= src_addr & c_align_mask;
                            r_req_left <= xfer_len;
                            r_rcv_left <= xfer_len;
                            r_last_idx <= xfer_len - 32'd1;
                            r_tx_cnt   <= '0;
                            r_rb_left  <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (w_arhs && (r_req_left == 32'd0)) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Leave on the final beat itself so the TLAST handshake is always seen in FLUSH
                    if (w_rbeat && (r_rcv_left == 32'd1)) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (w_tlast_hs) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_issue) begin
                r_arvalid  <= 1'b1;
                r_araddr   <= r_addr;
                r_arlen    <= 8'(w_blen - 32'd1);
                r_addr     <= r_addr + ADDR_W'(w_blen << c_size);
                r_req_left <= r_req_left - w_blen;
            end else if (w_arhs) begin
                r_arvalid  <= 1'b0;
            end

            if (w_rbeat) begin
                r_rcv_left <= r_rcv_left - 32'd1;
                r_rb_left  <= w_rcur - 32'd1;
                if (r_rb_left == 32'd0) begin
                    r_raddr <= r_raddr + ADDR_W'(w_rblen << c_size);
                end
                if ((RRESP != 2'b00) || (RLAST != (w_rcur == 32'd1))) begin
                    r_err <= 1'b1;
                end
            end
            if (w_rstray) begin
                r_err <= 1'b1;
            end

            r_outst <= r_outst + w_out_add - {{(c_cnt_w-1){1'b0}}, w_rbeat};
            r_fcnt  <= r_fcnt + {{(c_cnt_w-1){1'b0}}, w_rbeat} - {{(c_cnt_w-1){1'b0}}, w_frd};
            if (w_rbeat) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_frd) begin
                r_rptr   <= r_rptr + 1'b1;
                r_tx_cnt <= r_tx_cnt + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_mm2s_dma.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_axi_mm2s_dma
// Purpose  : Self-checking bench for axi_mm2s_dma with a randomized AXI read
//            slave and stream sink. Expected bursts and stream contents are
//            derived from the transfer parameters alone.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_mm2s_dma;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MAX_BURST  = 256;
    localparam int FIFO_DEPTH = 512;
    localparam int BYTES      = DATA_W / 8;

    logic                ACLK = 1'b0;
    logic                ARESETn = 1'b0;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   src_addr = '0;
    logic [31:0]         xfer_len = '0;
    logic                busy, done, err;
    logic                ARVALID;
    logic                ARREADY = 1'b0;
    logic [ADDR_W-1:0]   ARADDR;
    logic [7:0]          ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic                RVALID = 1'b0;
    logic                RREADY;
    logic [DATA_W-1:0]   RDATA = '0;
    logic [1:0]          RRESP = 2'b00;
    logic                RLAST = 1'b0;
    logic                TVALID;
    logic                TREADY = 1'b0;
    logic [DATA_W-1:0]   TDATA;
    logic [DATA_W/8-1:0] TKEEP;
    logic                TLAST;

    axi_mm2s_dma #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .start(start), .src_addr(src_addr), .xfer_len(xfer_len),
        .busy(busy), .done(done), .err(err),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .TVALID(TVALID), .TREADY(TREADY), .TDATA(TDATA), .TKEEP(TKEEP), .TLAST(TLAST)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic              last;
        int                idx;
    } rbeat_t;

    // Slave behaviour: 1 = always ready/valid, 2 = TREADY held low, otherwise random
    int ar_mode = 1, rv_mode = 1, t_mode = 1;
    int err_beat = -1;

    rbeat_t            rq[$];
    logic [ADDR_W-1:0] ar_addr_q[$];
    int                ar_len_q[$];
    logic [DATA_W-1:0] t_data_q[$];
    logic              t_last_q[$];

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, beat_ctr = 0, n_rhs = 0, n_ths = 0, n_ar_beats = 0, n_done = 0, d0 = 0;
    int done_cyc = -1, tlast_cyc = -1, first_rhs = -1, first_tv = -1;
    int max_occ = 0, max_resv = 0, stab_viol = 0, ar_viol = 0;
    logic done_busy = 1'b0;

    function automatic logic [DATA_W-1:0] dat(input logic [ADDR_W-1:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge ACLK);
        #1;
    endtask

    // AXI read slave, stream sink and protocol monitor, all evaluated mid-cycle
    logic              r_kept = 1'b0, prev_stall = 1'b0, prev_arstall = 1'b0;
    logic [DATA_W-1:0] prev_tdata = '0;
    logic [ADDR_W-1:0] prev_araddr = '0;
    logic [7:0]        prev_arlen = '0;
    always @(negedge ACLK) begin
        rbeat_t nb;
        cyc++;
        if (!ARESETn) begin
            RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00; ARREADY = 1'b0; TREADY = 1'b0;
            r_kept = 1'b0; prev_stall = 1'b0; prev_arstall = 1'b0;
        end else begin
            if (done) begin n_done++; done_cyc = cyc; done_busy = busy; end
            if (TVALID && first_tv < 0) first_tv = cyc;
            if (prev_stall && (!TVALID || TDATA !== prev_tdata)) stab_viol++;
            if (prev_arstall && (!ARVALID || ARADDR !== prev_araddr || ARLEN !== prev_arlen)) ar_viol++;
            if (!r_kept) begin
                if (rq.size() > 0 && (rv_mode == 1 || $urandom_range(3) != 0)) begin
                    RVALID = 1'b1;
                    RDATA  = dat(rq[0].a);
                    RLAST  = rq[0].last;
                    RRESP  = (rq[0].idx == err_beat) ? 2'b10 : 2'b00;
                end else begin
                    RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
                end
            end
            if (RVALID && RREADY) begin
                void'(rq.pop_front());
                n_rhs++;
                if (first_rhs < 0) first_rhs = cyc;
                r_kept = 1'b0;
            end else begin
                r_kept = RVALID;
            end
            ARREADY = (ar_mode == 1) ? 1'b1 : ($urandom_range(2) != 0);
            if (ARVALID && ARREADY) begin
                ar_addr_q.push_back(ARADDR);
                ar_len_q.push_back(int'(ARLEN));
                for (int i = 0; i <= int'(ARLEN); i++) begin
                    nb.a = ARADDR + ADDR_W'(i * BYTES);
                    nb.last = (i == int'(ARLEN));
                    nb.idx = beat_ctr;
                    beat_ctr++;
                    rq.push_back(nb);
                end
                n_ar_beats += int'(ARLEN) + 1;
            end
            TREADY = (t_mode == 1) ? 1'b1 : (t_mode == 2) ? 1'b0 : ($urandom_range(1) == 1);
            if (TVALID && TREADY) begin
                t_data_q.push_back(TDATA);
                t_last_q.push_back(TLAST);
                n_ths++;
                if (TLAST) tlast_cyc = cyc;
            end
            prev_stall   = TVALID && !TREADY;
            prev_tdata   = TDATA;
            prev_arstall = ARVALID && !ARREADY;
            prev_araddr  = ARADDR;
            prev_arlen   = ARLEN;
            if (n_rhs - n_ths > max_occ) max_occ = n_rhs - n_ths;
            if (n_ar_beats - n_ths > max_resv) max_resv = n_ar_beats - n_ths;
        end
    end

    task automatic start_xfer(input string tag, input logic [ADDR_W-1:0] a, input int len);
        ar_addr_q.delete(); ar_len_q.delete(); t_data_q.delete(); t_last_q.delete();
        beat_ctr = 0; n_rhs = 0; n_ths = 0; n_ar_beats = 0; max_occ = 0; max_resv = 0;
        first_rhs = -1; first_tv = -1; stab_viol = 0; ar_viol = 0; d0 = n_done;
        src_addr = a; xfer_len = 32'(len); start = 1'b1;
        tick(1);
        start = 1'b0;
        chk($sformatf("%s busy_after_start", tag), busy, 1);
        chk($sformatf("%s err_cleared", tag), err, 0);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && n_done == d0; i++) tick(1);
        tick(1);
    endtask

    task automatic check_xfer(input string tag, input logic [ADDR_W-1:0] a, input int len, input int exp_err);
        logic [ADDR_W-1:0] base, ea;
        logic [ADDR_W-1:0] eb_addr[$];
        int eb_len[$];
        int rem, n, bad, nlast, lastpos;
        base = a & ~ADDR_W'(BYTES - 1);
        ea = base; rem = len;
        while (rem > 0) begin
            n = (rem > MAX_BURST) ? MAX_BURST : rem;
`ifdef AXI_MM2S_4K_SPLIT_EN
            if (n > (4096 - int'(ea[11:0])) / BYTES) n = (4096 - int'(ea[11:0])) / BYTES;
`endif
            eb_addr.push_back(ea); eb_len.push_back(n - 1);
            ea += ADDR_W'(n * BYTES); rem -= n;
        end
        chk($sformatf("%s done_count", tag), n_done - d0, 1);
        chk($sformatf("%s done_after_tlast", tag), done_cyc, tlast_cyc + 1);
        chk($sformatf("%s busy_low_at_done", tag), done_busy, 0);
        chk($sformatf("%s beats", tag), t_data_q.size(), len);
        bad = 0; nlast = 0; lastpos = -1;
        foreach (t_data_q[i]) begin
            if (t_data_q[i] !== dat(base + ADDR_W'(i * BYTES))) bad++;
            if (t_last_q[i]) begin nlast++; lastpos = i; end
        end
        chk($sformatf("%s data_bad", tag), bad, 0);
        chk($sformatf("%s tlast_pos", tag), lastpos, len - 1);
        chk($sformatf("%s tlast_cnt", tag), nlast, 1);
        chk($sformatf("%s nbursts", tag), ar_addr_q.size(), eb_addr.size());
        bad = 0;
        for (int i = 0; i < eb_addr.size() && i < ar_addr_q.size(); i++)
            if (ar_addr_q[i] !== eb_addr[i] || ar_len_q[i] != eb_len[i]) bad++;
        chk($sformatf("%s burst_bad", tag), bad, 0);
        chk($sformatf("%s err", tag), err, exp_err);
        chk($sformatf("%s fifo_no_overflow", tag), max_occ <= FIFO_DEPTH, 1);
        chk($sformatf("%s reserve_bound", tag), max_resv <= FIFO_DEPTH, 1);
        chk($sformatf("%s first_tvalid_latency", tag), (first_tv > first_rhs) && (first_tv - first_rhs <= 2), 1);
        chk($sformatf("%s tdata_stable", tag), stab_viol, 0);
        chk($sformatf("%s ar_stable", tag), ar_viol, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] ra;
        int rl;
        tick(3);
        chk("rst ARVALID", ARVALID, 0);
        chk("rst RREADY", RREADY, 0);
        chk("rst TVALID", TVALID, 0);
        chk("rst TLAST", TLAST, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst ARADDR", ARADDR, 0);
        chk("rst ARLEN", ARLEN, 0);
        ARESETn = 1'b1;
        tick(2);
        chk("ARSIZE", ARSIZE, 2);
        chk("ARBURST", ARBURST, 1);
        chk("TKEEP", TKEEP, 4'hF);

        // 600 beats from 0 with all handshakes ready, plus a start while busy
        ar_mode = 1; rv_mode = 1; t_mode = 1;
        start_xfer("s600", 32'h0, 600);
        tick(100);
        src_addr = 32'h5000; xfer_len = 32'd7; start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(5000);
        check_xfer("s600", 32'h0, 600, 0);
        chk("s600 arlen0", ar_len_q.size() > 0 ? ar_len_q[0] : -1, 255);
        chk("s600 arlen1", ar_len_q.size() > 1 ? ar_len_q[1] : -1, 255);
        chk("s600 arlen2", ar_len_q.size() > 2 ? ar_len_q[2] : -1, 87);

        // 4KB boundary case
        start_xfer("k4", 32'hF80, 64);
        wait_done(1000);
        check_xfer("k4", 32'hF80, 64, 0);
`ifdef AXI_MM2S_4K_SPLIT_EN
        chk("k4 split_n", ar_addr_q.size(), 2);
        chk("k4 addr1", ar_addr_q.size() > 1 ? longint'(ar_addr_q[1]) : -1, 32'h1000);
        chk("k4 len0", ar_len_q.size() > 0 ? ar_len_q[0] : -1, 31);
`else
        chk("k4 single_n", ar_addr_q.size(), 1);
        chk("k4 len0", ar_len_q.size() > 0 ? ar_len_q[0] : -1, 63);
`endif

        // Stream stalled: reservation must cap AR issue at the FIFO depth
        ar_mode = 0; rv_mode = 0; t_mode = 2;
        start_xfer("stall", 32'h2000, 1024);
        tick(2000);
        chk("stall reserved_beats", n_ar_beats, 512);
        chk("stall received_beats", n_rhs, 512);
        chk("stall tvalid", TVALID, 1);
        t_mode = 1;
        wait_done(9000);
        check_xfer("stall", 32'h2000, 1024, 0);

        // Zero-length transfer
        ar_addr_q.delete(); d0 = n_done;
        src_addr = 32'h40; xfer_len = 32'd0; start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("zero done_pulse", done, 1);
        chk("zero busy", busy, 0);
        tick(1);
        chk("zero done_low", done, 0);
        tick(10);
        chk("zero no_ar", ar_addr_q.size(), 0);
        chk("zero done_count", n_done - d0, 1);
        chk("zero err", err, 0);
        chk("zero busy_after", busy, 0);

        // Error response on beat 5; err is sticky until the next start
        ar_mode = 0; rv_mode = 0; t_mode = 0; err_beat = 5;
        start_xfer("rerr", 32'h300, 16);
        wait_done(500);
        check_xfer("rerr", 32'h300, 16, 1);
        err_beat = -1;
        tick(5);
        chk("rerr sticky", err, 1);
        start_xfer("clr", 32'h400, 4);
        wait_done(200);
        check_xfer("clr", 32'h400, 4, 0);

        // Reset in the middle of a transfer
        start_xfer("mrst", 32'h8000, 300);
        tick(40);
        ARESETn = 1'b0;
        tick(1);
        chk("mrst ARVALID", ARVALID, 0);
        chk("mrst RREADY", RREADY, 0);
        chk("mrst TVALID", TVALID, 0);
        chk("mrst TLAST", TLAST, 0);
        chk("mrst busy", busy, 0);
        chk("mrst err", err, 0);
        chk("mrst ARADDR", ARADDR, 0);
        chk("mrst ARLEN", ARLEN, 0);
        rq.delete();
        tick(2);
        ARESETn = 1'b1;
        tick(2);
        start_xfer("post_rst", 32'h9000, 40);
        wait_done(500);
        check_xfer("post_rst", 32'h9000, 40, 0);

        // Randomized transfers and handshake patterns
        for (int k = 0; k < 4; k++) begin
            ar_mode = int'($urandom_range(1)); rv_mode = int'($urandom_range(1)); t_mode = int'($urandom_range(1)) * 1;
            if ($urandom_range(1) == 0) t_mode = 0;
            ra = ADDR_W'($urandom_range(32'h000F_FFFF));
            rl = int'($urandom_range(700, 1));
            start_xfer($sformatf("rnd%0d", k), ra, rl);
            wait_done(8 * rl + 200);
            check_xfer($sformatf("rnd%0d", k), ra, rl, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
